// File: rtl/instr_sequencer_if.sv
// Instruction-memory fetch bus between the sequencer and instruction memory.
//   imem_req   : fetch request, held until imem_ack is seen
//   imem_addr  : fetch address, stable while imem_req is high
//   imem_ack   : fetch completion; imem_rdata is valid in the same cycle
//   imem_rdata : fetched instruction word
// master = sequencer side, slave = memory side.
interface instr_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/instr_sequencer.sv
// Fetch/execute sequencer for a single-issue core.
// Fetches one word at pc over the imem bus, holds it in instr for the decoder,
// retires it in a one-cycle EXEC state (gated rf_we, retire pulse, pc += 4,
// instret += 1), optionally pauses in HALT, and locks up in FAULT when the
// memory fails to acknowledge within TIMEOUT fetch cycles.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   imem        : fetch bus (master modport)
//   instr       : latched instruction word
//   ctrl_rf_we  : decoder write enable; rf_we is its EXEC-gated copy
//   halt_req    : pause request, honoured at the end of EXEC
//   pc          : program counter
//   retire      : one-cycle pulse per completed instruction
//   instret     : retired-instruction counter
//   halted      : high while in HALT
//   fault       : high while in FAULT
module instr_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  instr_sequencer_if.master          imem,
  output logic [31:0]                instr,
  input  logic                       ctrl_rf_we,
  output logic                       rf_we,
  input  logic                       halt_req,
  output logic [31:0]                pc,
  output logic                       retire,
  output logic [31:0]                instret,
  output logic                       halted,
  output logic                       fault
);

  localparam logic [7:0] TmoLast = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    StFetch,
    StExec,
    StHalt,
    StFault
  } state_e;

  state_e      state_q;
  // Low while reset is pending release: the state is FETCH but no request is
  // issued until the first clock edge after rst drops.
  logic        run_q;
  logic [7:0]  tmo_q;
  logic [31:0] instr_q;
  logic [31:0] pc_q;
  logic [31:0] instret_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StFetch;
      run_q     <= 1'b0;
      tmo_q     <= 8'd0;
      instr_q   <= 32'd0;
      pc_q      <= RESET_PC;
      instret_q <= 32'd0;
    end else if (!run_q) begin
      run_q <= 1'b1;
    end else begin
      unique case (state_q)
        StFetch: begin
          if (imem.imem_ack) begin
            instr_q <= imem.imem_rdata;
            tmo_q   <= 8'd0;
            state_q <= StExec;
          end else if (tmo_q == TmoLast) begin
            state_q <= StFault;
          end else begin
            tmo_q <= tmo_q + 8'd1;
          end
        end
        StExec: begin
          pc_q      <= pc_q + 32'd4;
          instret_q <= instret_q + 32'd1;
          state_q   <= halt_req ? StHalt : StFetch;
        end
        StHalt: begin
          if (!halt_req) begin
            state_q <= StFetch;
          end
        end
        StFault: begin
          // Terminal until reset; all architectural state frozen.
        end
        default: state_q <= StFault;
      endcase
    end
  end

  // Outputs decode the state register only, so an asynchronous reset drops
  // rf_we/retire in the same instant it is asserted.
  always_comb begin
    imem.imem_req  = run_q && (state_q == StFetch);
    imem.imem_addr = pc_q;
    rf_we          = (state_q == StExec) && ctrl_rf_we;
    retire         = (state_q == StExec);
    halted         = (state_q == StHalt);
    fault          = (state_q == StFault);
    instr          = instr_q;
    pc             = pc_q;
    instret        = instret_q;
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Randomized scoreboard bench for instr_sequencer: the driver pushes the
// expected retirement record for every acknowledged fetch and a separate
// monitor pops and compares whenever the sequencer pulses retire.
module tb_instr_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  instr_sequencer_if bus ();
  logic [31:0] instr, pc, instret;
  logic        ctrl_rf_we = 1'b0;
  logic        halt_req   = 1'b0;
  logic        rf_we, retire, halted, fault;

  instr_sequencer #(
    .RESET_PC (32'h0000_0000),
    .TIMEOUT  (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .imem       (bus.master),
    .instr      (instr),
    .ctrl_rf_we (ctrl_rf_we),
    .rf_we      (rf_we),
    .halt_req   (halt_req),
    .pc         (pc),
    .retire     (retire),
    .instret    (instret),
    .halted     (halted),
    .fault      (fault)
  );

  // Second instance starting just below the top of the address space.
  logic rst_w = 1'b0;
  instr_sequencer_if bus_w ();
  logic [31:0] instr_w, pc_w, instret_w;
  logic        rf_we_w, retire_w, halted_w, fault_w;

  instr_sequencer #(
    .RESET_PC (32'hFFFF_FFFC),
    .TIMEOUT  (16)
  ) dut_w (
    .clk        (clk),
    .rst        (rst_w),
    .imem       (bus_w.master),
    .instr      (instr_w),
    .ctrl_rf_we (1'b1),
    .rf_we      (rf_we_w),
    .halt_req   (1'b0),
    .pc         (pc_w),
    .retire     (retire_w),
    .instret    (instret_w),
    .halted     (halted_w),
    .fault      (fault_w)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] instret;
    logic        we;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: pc = RESET_PC + 4 * retired, instret = retired.
  logic [31:0] m_pc       = 32'h0;
  logic [31:0] m_instret  = 32'h0;
  logic [31:0] last_instr = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  // Monitor: every retire pulse must match the oldest outstanding fetch.
  always @(negedge clk) begin
    if (retire === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_retire: got retire=1 want no retire (pc=%h)", pc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("ret_instr", instr, e.instr);
        chk1("ret_rf_we", rf_we, e.we);
        chk("ret_pc", pc, e.pc);
        chk("ret_instret", instret, e.instret);
      end
    end
  end

  // Called at a negedge with the DUT in FETCH. Acks after 'delay' idle cycles,
  // then optionally holds halt_req so the DUT sits in HALT for 'hold' cycles.
  task automatic fetch_one(input int delay, input logic [31:0] word, input logic we,
                           input int hold);
    bus.imem_ack = 1'b0;
    for (int i = 0; i < delay; i++) begin
      chk1("wait_req", bus.imem_req, 1'b1);
      chk("wait_addr", bus.imem_addr, m_pc);
      chk("wait_instr", instr, last_instr);
      chk1("wait_fault", fault, 1'b0);
      @(negedge clk);
    end
    chk1("fetch_req", bus.imem_req, 1'b1);
    chk("fetch_addr", bus.imem_addr, m_pc);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = word;
    ctrl_rf_we     = we;
    halt_req       = (hold > 0);
    sb.push_back('{pc: m_pc, instr: word, instret: m_instret, we: we});
    m_pc       = m_pc + 32'd4;
    m_instret  = m_instret + 32'd1;
    last_instr = word;
    @(negedge clk);
    // EXEC: any ack now must be ignored.
    chk1("exec_req", bus.imem_req, 1'b0);
    bus.imem_ack   = 1'($urandom_range(0, 1));
    bus.imem_rdata = $urandom;
    @(negedge clk);
    bus.imem_ack = 1'b0;
    for (int i = 0; i < hold; i++) begin
      chk1("halt_halted", halted, 1'b1);
      chk1("halt_req", bus.imem_req, 1'b0);
      chk1("halt_retire", retire, 1'b0);
      chk("halt_pc", pc, m_pc);
      chk("halt_instr", instr, last_instr);
      if (i == hold - 1) halt_req = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.imem_ack     = 1'b0;
    bus.imem_rdata   = 32'h0;
    bus_w.imem_ack   = 1'b0;
    bus_w.imem_rdata = 32'h0;
    #1 rst = 1'b1;
    rst_w = 1'b1;
    #2;
    chk1("rst_req", bus.imem_req, 1'b0);
    chk1("rst_fault", fault, 1'b0);
    chk1("rst_halted", halted, 1'b0);
    chk1("rst_retire", retire, 1'b0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instret", instret, 32'h0);

    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk1("rel_req", bus.imem_req, 1'b1);
    chk("rel_addr", bus.imem_addr, 32'h0);
    chk1("rel_rf_we", rf_we, 1'b0);
    chk1("rel_fault", fault, 1'b0);
    chk("rel_instret", instret, 32'h0);

    // ADDI x1,x0,5 at full throughput.
    fetch_one(0, 32'h0050_0093, 1'b1, 0);
    chk("addi_pc", pc, 32'd4);
    chk("addi_instret", instret, 32'd1);
    chk1("addi_req", bus.imem_req, 1'b1);
    // Slow memory at pc=4, then halt requested during the fetch at pc=8.
    fetch_one(3, $urandom, 1'b0, 0);
    fetch_one(1, $urandom, 1'b1, 2);
    chk1("unhalt_req", bus.imem_req, 1'b1);
    chk("unhalt_addr", bus.imem_addr, 32'd12);

    repeat (60) begin
      int h;
      h = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0;
      fetch_one(int'($urandom_range(0, 5)), $urandom, 1'($urandom_range(0, 1)), h);
    end

    // Reset asserted in the middle of EXEC.
    chk1("mid_req", bus.imem_req, 1'b1);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'hDEAD_BEEF;
    ctrl_rf_we     = 1'b1;
    sb.push_back('{pc: m_pc, instr: 32'hDEAD_BEEF, instret: m_instret, we: 1'b1});
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk1("mid_rf_we", rf_we, 1'b0);
    chk1("mid_retire", retire, 1'b0);
    chk1("mid_req0", bus.imem_req, 1'b0);
    chk("mid_instr", instr, 32'h0);
    @(posedge clk);
    #1;
    chk("mid_pc", pc, 32'h0);
    chk("mid_instret", instret, 32'h0);
    m_pc       = 32'h0;
    m_instret  = 32'h0;
    last_instr = 32'h0;
    bus.imem_ack = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    fetch_one(2, $urandom, 1'b1, 0);
    fetch_one(0, $urandom, 1'b0, 0);

    // Fetch timeout: 16 unacknowledged FETCH cycles, then FAULT.
    bus.imem_ack = 1'b0;
    for (int k = 0; k < 16; k++) begin
      chk1("tmo_fault0", fault, 1'b0);
      chk1("tmo_req", bus.imem_req, 1'b1);
      @(negedge clk);
    end
    chk1("tmo_fault", fault, 1'b1);
    chk1("tmo_req0", bus.imem_req, 1'b0);
    chk1("tmo_halted", halted, 1'b0);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h1234_5678;
    repeat (3) @(negedge clk);
    chk1("tmo_stuck", fault, 1'b1);
    chk("tmo_pc", pc, m_pc);
    chk("tmo_instret", instret, m_instret);
    chk("tmo_instr", instr, last_instr);
    bus.imem_ack = 1'b0;
    rst = 1'b1;
    #1 chk1("tmo_rst_fault", fault, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Wrap: instret = 2^32-1 and pc = 2^32-4, one retire -> both zero.
    rst_w = 1'b0;
    force dut_w.instret_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut_w.instret_q;
    chk("wrap_pre_instret", instret_w, 32'hFFFF_FFFF);
    chk("wrap_pre_addr", bus_w.imem_addr, 32'hFFFF_FFFC);
    chk1("wrap_pre_req", bus_w.imem_req, 1'b1);
    bus_w.imem_ack   = 1'b1;
    bus_w.imem_rdata = 32'h0000_0013;
    @(negedge clk);
    bus_w.imem_ack = 1'b0;
    chk1("wrap_retire", retire_w, 1'b1);
    chk1("wrap_rf_we", rf_we_w, 1'b1);
    @(negedge clk);
    chk("wrap_instret", instret_w, 32'h0);
    chk("wrap_pc", pc_w, 32'h0);
    chk("wrap_addr", bus_w.imem_addr, 32'h0);
    rst_w = 1'b1;

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, program counter value loaded on reset.
REQ-002 Parameter TIMEOUT, 16, maximum FETCH cycles without imem_ack before fault (range 2..255).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 imem_req  output  1  instruction fetch request.
REQ-006 imem_addr  output  32  fetch address; equals pc.
REQ-007 imem_ack  input  1  fetch completion; imem_rdata valid in same cycle.
REQ-008 imem_rdata  input  32  fetched instruction word.
REQ-009 instr  output  32  latched instruction word; drives the combinational decoder.
REQ-010 ctrl_rf_we  input  1  register-file write enable from the decoder.
REQ-011 rf_we  output  1  gated register-file write enable to the datapath.
REQ-012 halt_req  input  1  request to pause after the current instruction.
REQ-013 pc  output  32  current program counter.
REQ-014 retire  output  1  one-cycle pulse per completed instruction.
REQ-015 instret  output  32  retired-instruction counter.
REQ-016 halted  output  1  high while in HALT.
REQ-017 fault  output  1  high while in FAULT (fetch timeout).

Function
REQ-018 FSM states SHALL be FETCH, EXEC, HALT, FAULT; encoding free.
REQ-019 FETCH: imem_req=1, imem_addr=pc; held high, address stable, until imem_ack sampled high.
REQ-020 FETCH with imem_ack=1: instr <= imem_rdata, timeout counter <= 0, next EXEC.
REQ-021 FETCH with imem_ack=0: timeout counter +1; when counter reaches TIMEOUT-1 and imem_ack=0, next FAULT.
REQ-022 imem_ack outside FETCH SHALL be ignored (instr, pc, state unchanged).
REQ-023 EXEC lasts exactly one cycle: rf_we=ctrl_rf_we, retire=1, pc <= pc+4 (modulo 2^32), instret <= instret+1 (wraps 32'hFFFF_FFFF -> 0).
REQ-024 EXEC next state: HALT if halt_req=1 in that cycle, else FETCH.
REQ-025 rf_we and retire SHALL be 0 in every state other than EXEC.
REQ-026 halt_req during FETCH SHALL NOT abort the fetch; instruction completes, halt taken at end of EXEC.
REQ-027 HALT: imem_req=0, halted=1; next FETCH (same pc) on first cycle halt_req=0.
REQ-028 FAULT: imem_req=0, fault=1, pc/instr/instret frozen; exited only by rst.
REQ-029 Minimum throughput: one instruction per 2 cycles (ack in first FETCH cycle).
REQ-030 instr SHALL hold its value through EXEC, HALT and subsequent FETCH until the next ack.
REQ-031 All outputs except instr, pc, instret SHALL be combinational decodes of state only (plus ctrl_rf_we for rf_we).

Reset
REQ-032 rst=1 SHALL immediately force state FETCH-pending-release: imem_req=0, rf_we=0, retire=0, halted=0, fault=0, pc=RESET_PC, instr=0, instret=0, timeout counter=0.
REQ-033 First rising clk edge with rst=0 enters FETCH; imem_req=1 from that cycle with imem_addr=RESET_PC.
REQ-034 rst asserted mid-EXEC SHALL drop rf_we asynchronously; no register-file write or pc increment from that cycle.

Verification
REQ-035 Reset: rst pulse, release -> next cycle imem_req=1, imem_addr=0, rf_we=0, fault=0, instret=0.
REQ-036 ADDI x1,x0,5: imem_rdata=32'h0050_0093, ack in first FETCH cycle, ctrl_rf_we=1 -> next cycle instr=32'h0050_0093, rf_we=1, retire=1 for one cycle; then pc=4, instret=1, imem_req=1.
REQ-037 Slow memory: ack after 3 cycles -> imem_req high and imem_addr constant 3 cycles, instr unchanged until ack; no fault.
REQ-038 Timeout: imem_ack held 0, TIMEOUT=16 -> fault=1 after 16 FETCH cycles, imem_req=0, stays until rst.
REQ-039 Halt: halt_req=1 during FETCH at pc=8 -> EXEC retires, then halted=1, imem_req=0; release halt_req -> FETCH at imem_addr=12.
REQ-040 Wrap: preload via 2^32-1 retires (or force) instret=32'hFFFF_FFFF, pc=32'hFFFF_FFFC, one retire -> instret=0, pc=0.
